// File: rtl/iq_fir_scheduler.sv
// iq_fir_scheduler: round-robin I/Q arbiter and sweep controller
// for one shared symmetric-FIR multiply-accumulate datapath.
module iq_fir_scheduler #(
    parameter int NTAP_PAIRS = 4,
    localparam int TAP_W = (NTAP_PAIRS > 1) ? $clog2(NTAP_PAIRS) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic             q_valid,
    output logic             q_ready,
    output logic             shift_en_i,
    output logic             shift_en_q,
    output logic             chan_sel,
    output logic [TAP_W-1:0] tap_sel,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             out_valid,
    output logic             out_chan,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NTAP_PAIRS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TAP_W-1:0] tap;
    logic [TAP_W-1:0] tap_nxt;
    logic             chan;
    logic             chan_nxt;
    logic             last_chan;
    logic             last_chan_nxt;
    logic             grant_q;
    logic             fire_i;
    logic             fire_q;
    logic             idle;

    // Q wins when it is alone, or on a tie (both or none) when I went last
    assign grant_q = (q_valid & ~i_valid)
                   | (~(i_valid ^ q_valid) & ~last_chan);

    assign idle    = (state == IDLE);
    assign i_ready = resetn & idle & ~grant_q;
    assign q_ready = resetn & idle & grant_q;
    assign fire_i  = i_ready & i_valid;
    assign fire_q  = q_ready & q_valid;
    assign busy    = ~idle;

    // State, tap counter and channel bookkeeping registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            tap       <= '0;
            chan      <= 1'b0;
            last_chan <= 1'b1;
        end else begin
            state     <= state_nxt;
            tap       <= tap_nxt;
            chan      <= chan_nxt;
            last_chan <= last_chan_nxt;
        end
    end

    // Next-state logic and datapath control decode
    always_comb begin
        state_nxt     = state;
        tap_nxt       = tap;
        chan_nxt      = chan;
        last_chan_nxt = last_chan;
        shift_en_i    = 1'b0;
        shift_en_q    = 1'b0;
        acc_clr       = 1'b0;
        acc_en        = 1'b0;
        out_valid     = 1'b0;
        out_chan      = 1'b0;
        chan_sel      = chan;
        tap_sel       = '0;
        unique case (state)
            IDLE: begin
                if (fire_i | fire_q) begin
                    shift_en_i = fire_i;
                    shift_en_q = fire_q;
                    acc_clr    = 1'b1;
                    chan_sel   = fire_q;
                    chan_nxt   = fire_q;
                    tap_nxt    = '0;
                    state_nxt  = MAC;
                end
            end
            MAC: begin
                acc_en  = 1'b1;
                tap_sel = tap;
                if (tap == TAP_LAST) begin
                    tap_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    tap_nxt = tap + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_chan  = chan;
                if (out_ready) begin
                    last_chan_nxt = chan;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iq_fir_scheduler.sv
// tb_iq_fir_scheduler: directed stimulus with a queue scoreboard
// checking channel and arrival cycle of every finished result.
module tb_iq_fir_scheduler;

    typedef struct {
        logic chan;
        int   due;
    } exp_t;

    logic       clk;
    logic       resetn;
    logic       i_valid;
    logic       q_valid;
    logic       out_ready;
    logic       i_ready;
    logic       q_ready;
    logic       shift_en_i;
    logic       shift_en_q;
    logic       chan_sel;
    logic [1:0] tap_sel;
    logic       acc_clr;
    logic       acc_en;
    logic       out_valid;
    logic       out_chan;
    logic       busy;

    logic       i8_valid;
    logic       q8_valid;
    logic       i8_ready;
    logic       q8_ready;
    logic       shi8;
    logic       shq8;
    logic       csel8;
    logic [2:0] tap8;
    logic       clr8;
    logic       acc8;
    logic       ov8;
    logic       oc8;
    logic       busy8;

    exp_t sb[$];
    exp_t sb8[$];
    int   cyc;
    int   n_chk;
    int   n_pass;

    iq_fir_scheduler dut (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_ready(i_ready),
        .q_valid(q_valid), .q_ready(q_ready),
        .shift_en_i(shift_en_i), .shift_en_q(shift_en_q),
        .chan_sel(chan_sel), .tap_sel(tap_sel),
        .acc_clr(acc_clr), .acc_en(acc_en),
        .out_valid(out_valid), .out_chan(out_chan),
        .out_ready(out_ready), .busy(busy)
    );

    iq_fir_scheduler #(.NTAP_PAIRS(8)) dut8 (
        .clk(clk), .resetn(resetn),
        .i_valid(i8_valid), .i_ready(i8_ready),
        .q_valid(q8_valid), .q_ready(q8_ready),
        .shift_en_i(shi8), .shift_en_q(shq8),
        .chan_sel(csel8), .tap_sel(tap8),
        .acc_clr(clr8), .acc_en(acc8),
        .out_valid(ov8), .out_chan(oc8),
        .out_ready(1'b1), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    // Scoreboard monitor for the default instance
    always @(negedge clk) begin
        exp_t e;
        if (resetn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_chan", int'(out_chan), int'(e.chan));
                check("out_cycle", cyc, e.due);
            end
        end
    end

    // Scoreboard monitor for the 8-pair instance
    always @(negedge clk) begin
        exp_t e;
        if (resetn && ov8) begin
            if (sb8.size() == 0) begin
                check("unexpected_out8", 1, 0);
            end else begin
                e = sb8.pop_front();
                check("out_chan8", int'(oc8), int'(e.chan));
                check("out_cycle8", cyc, e.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        n_chk++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        cyc = 0;
        n_chk = 0;
        n_pass = 0;
        resetn = 1'b0;
        i_valid = 1'b1;
        q_valid = 1'b0;
        out_ready = 1'b1;
        i8_valid = 1'b0;
        q8_valid = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_i_ready", int'(i_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_acc_en", int'(acc_en), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_tap_sel", int'(tap_sel), 0);
        check("rst_chan_sel", int'(chan_sel), 0);

        // single I sample after reset release
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        check("t1_i_ready", int'(i_ready), 1);
        check("t1_q_ready", int'(q_ready), 0);
        check("t1_shift_i", int'(shift_en_i), 1);
        check("t1_acc_clr", int'(acc_clr), 1);
        check("t1_chan_sel", int'(chan_sel), 0);
        sb.push_back('{1'b0, cyc + 5});
        @(posedge clk); #1 i_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            else @(negedge clk);
            check("t1_tap_sel", int'(tap_sel), k);
            check("t1_acc_en", int'(acc_en), 1);
            check("t1_busy", int'(busy), 1);
        end
        @(negedge clk);
        check("t1_done_valid", int'(out_valid), 1);
        check("t1_done_acc_en", int'(acc_en), 0);
        @(negedge clk);
        check("t1_back_idle", int'(busy), 0);

        // both valids: alternating grants every 6 cycles
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        i_valid = 1'b1;
        q_valid = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            check("t2_i_ready", int'(i_ready), (s % 2 == 0) ? 1 : 0);
            check("t2_q_ready", int'(q_ready), (s % 2 == 0) ? 0 : 1);
            sb.push_back('{logic'(s % 2), cyc + 5});
            if (s == 3) begin
                @(posedge clk); #1;
                i_valid = 1'b0;
                q_valid = 1'b0;
                repeat (5) @(negedge clk);
            end else begin
                repeat (6) @(negedge clk);
            end
        end

        // backpressure on the result for 10 cycles
        @(posedge clk); #1;
        i_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("t3_i_ready", int'(i_ready), 1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        q_valid = 1'b1;
        repeat (4) @(negedge clk);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("t3_hold_valid", int'(out_valid), 1);
            check("t3_hold_i_ready", int'(i_ready), 0);
            check("t3_hold_q_ready", int'(q_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        sb.push_back('{1'b0, cyc});
        @(negedge clk);
        check("t3_still_busy", int'(busy), 1);
        @(negedge clk);
        check("t3_idle", int'(busy), 0);

        // Q only, three samples back to back
        for (int s = 0; s < 3; s++) begin
            check("t4_q_ready", int'(q_ready), 1);
            check("t4_i_ready", int'(i_ready), 0);
            check("t4_shift_q", int'(shift_en_q), 1);
            check("t4_chan_sel_acc", int'(chan_sel), 1);
            sb.push_back('{1'b1, cyc + 5});
            if (s == 2) begin
                @(posedge clk); #1 q_valid = 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("t4_chan_sel_mac", int'(chan_sel), 1);
            end
            @(negedge clk);
            check("t4_chan_sel_done", int'(chan_sel), 1);
            @(negedge clk);
        end

        // reset in the middle of a sweep
        @(posedge clk); #1 i_valid = 1'b1;
        @(negedge clk);
        check("t5_i_ready", int'(i_ready), 1);
        sb.push_back('{1'b0, cyc + 5});
        @(posedge clk); #1 i_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_tap_sel", int'(tap_sel), 2);
        #1 resetn = 1'b0;
        #1;
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_acc_en", int'(acc_en), 0);
        check("t5_rst_out_valid", int'(out_valid), 0);
        sb.delete();
        i_valid = 1'b1;
        q_valid = 1'b1;
        check("t5_rst_q_ready", int'(q_ready), 0);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        check("t5_first_i", int'(i_ready), 1);
        check("t5_first_q", int'(q_ready), 0);
        sb.push_back('{1'b0, cyc + 5});
        @(posedge clk); #1;
        i_valid = 1'b0;
        q_valid = 1'b0;
        repeat (6) @(negedge clk);

        // eight tap pairs
        @(posedge clk); #1 i8_valid = 1'b1;
        @(negedge clk);
        check("t6_i_ready", int'(i8_ready), 1);
        check("t6_acc_clr", int'(clr8), 1);
        sb8.push_back('{1'b0, cyc + 9});
        @(posedge clk); #1 i8_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t6_tap_sel", int'(tap8), k);
            check("t6_acc_en", int'(acc8), 1);
        end
        repeat (3) @(negedge clk);

        check("sb_drained", sb.size(), 0);
        check("sb8_drained", sb8.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
